mem_lsu: RTL and testbench

Load/store sequencer sitting between the MEM pipeline stage and the `dm_4k` data memory: it is the initiator that drives the memory's `addr`/`din`/`we`/`memRead` port. It accepts one request at a time over a valid/ready handshake and issues the matching `dm_4k` operation codes. Halfword and unaligned word accesses are synthesised from per-byte SB/LBU operations, one per cycle. Results return as a single-cycle response pulse.

---
 rtl/mem_lsu_pkg.sv | 42 ++++
 rtl/lsu_extend.sv | 25 ++
 rtl/mem_lsu.sv | 143 ++++++++++++++
 tb/tb_mem_lsu.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the load/store sequencer: request ops, dm_4k port codes, FSM states.
package mem_lsu_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_SW   = 2'b01;
  localparam logic [1:0] WE_SB   = 2'b10;

  localparam logic [1:0] RD_NONE = 2'b00;
  localparam logic [1:0] RD_LW   = 2'b01;
  localparam logic [1:0] RD_LB   = 2'b10;
  localparam logic [1:0] RD_LBU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  function automatic logic is_store(op_e op);
    return op inside {OP_SW, OP_SH, OP_SB};
  endfunction

  function automatic logic is_half(op_e op);
    return op inside {OP_LH, OP_LHU, OP_SH};
  endfunction

  function automatic logic is_word(op_e op);
    return op inside {OP_LW, OP_SW};
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load result formatting: picks the byte-assembly value or dm_4k dout and extends by op.
// Purely combinational; stores always yield zero.
module lsu_extend
  import mem_lsu_pkg::*;
(
  input  op_e         op_i,
  input  logic        split_i,
  input  logic [31:0] asm_i,
  input  logic [31:0] dout_i,
  output logic [31:0] rdata_o
);

  always_comb begin
    rdata_o = dout_i;
    if (split_i) begin
      case (op_i)
        OP_LH:   rdata_o = {{16{asm_i[15]}}, asm_i[15:0]};
        OP_LHU:  rdata_o = {16'd0, asm_i[15:0]};
        default: rdata_o = asm_i;
      endcase
    end
    if (is_store(op_i)) rdata_o = 32'd0;
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store sequencer driving dm_4k; halfwords and misaligned words are built from byte ops.
// Latency n+1 edges to resp (n = 0/1/2/4 steps); req_ready only in IDLE, one request in flight.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter bit ALLOW_UNALIGNED = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_op_i,
  input  logic [11:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [11:0] dm_addr_o,
  output logic [31:0] dm_din_o,
  output logic [1:0]  dm_we_o,
  output logic [1:0]  dm_memRead_o,
  input  logic [31:0] dm_dout_i
);

  state_e      state_q;
  op_e         op_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  k_q, last_k_q;
  logic        split_q;
  logic [31:0] asm_q, asm_d;
  logic        resp_valid_q, resp_err_q;
  logic [31:0] resp_rdata_q;

  op_e         req_op;
  logic        misal_req, split_req, reject_req;
  logic [11:0] step_addr;
  logic [31:0] ext_rdata;

  assign req_op     = op_e'(req_op_i);
  assign misal_req  = (is_word(req_op) && (req_addr_i[1:0] != 2'b00)) ||
                      (is_half(req_op) && req_addr_i[0]);
  assign split_req  = is_half(req_op) || (is_word(req_op) && (req_addr_i[1:0] != 2'b00));
  assign reject_req = !ALLOW_UNALIGNED && misal_req;
  assign step_addr  = addr_q + {10'd0, k_q};

  // The byte landing this cycle is merged before extension so the last step needs no extra cycle.
  always_comb begin
    asm_d = asm_q;
    asm_d[{k_q, 3'b000} +: 8] = dm_dout_i[7:0];
  end

  lsu_extend u_extend (
    .op_i    (op_q),
    .split_i (split_q),
    .asm_i   (asm_d),
    .dout_i  (dm_dout_i),
    .rdata_o (ext_rdata)
  );

  always_comb begin
    dm_addr_o    = 12'd0;
    dm_din_o     = 32'd0;
    dm_we_o      = WE_NONE;
    dm_memRead_o = RD_NONE;
    if (state_q == S_ACCESS) begin
      if (split_q) begin
        dm_addr_o = step_addr;
        if (is_store(op_q)) begin
          dm_we_o  = WE_SB;
          dm_din_o = {24'd0, wdata_q[{k_q, 3'b000} +: 8]};
        end else begin
          dm_memRead_o = RD_LBU;
        end
      end else begin
        dm_addr_o = addr_q;
        case (op_q)
          OP_LW:   dm_memRead_o = RD_LW;
          OP_LB:   dm_memRead_o = RD_LB;
          OP_LBU:  dm_memRead_o = RD_LBU;
          OP_SW:   begin dm_we_o = WE_SW; dm_din_o = wdata_q; end
          OP_SB:   begin dm_we_o = WE_SB; dm_din_o = wdata_q; end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      op_q         <= OP_LW;
      addr_q       <= 12'd0;
      wdata_q      <= 32'd0;
      k_q          <= 2'd0;
      last_k_q     <= 2'd0;
      split_q      <= 1'b0;
      asm_q        <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (req_valid_i) begin
          op_q     <= req_op;
          addr_q   <= req_addr_i;
          wdata_q  <= req_wdata_i;
          k_q      <= 2'd0;
          asm_q    <= 32'd0;
          split_q  <= split_req;
          last_k_q <= is_half(req_op) ? 2'd1 : (split_req ? 2'd3 : 2'd0);
          if (reject_req) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= 32'd0;
          end else begin
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          asm_q <= asm_d;
          k_q   <= k_q + 2'd1;
          if (k_q == last_k_q) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= ext_rdata;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: two instances (unaligned allowed / rejected) each on a byte-array dm_4k model.
module tb_mem_lsu;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3;
  localparam logic [2:0] LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid[2], req_ready[2], resp_valid[2], resp_err[2];
  logic [2:0]  req_op[2];
  logic [11:0] req_addr[2], dm_addr[2];
  logic [31:0] req_wdata[2], resp_rdata[2], dm_din[2], dm_dout[2];
  logic [1:0]  dm_we[2], dm_memRead[2];

  bit [7:0] dm_mem[2][4096];
  bit [7:0] ref_mem[2][4096];

  int checks = 0;
  int failures = 0;

  logic [1:0]  we_log[$];
  logic [1:0]  rd_log[$];
  logic [11:0] addr_log[$];
  logic [7:0]  din_log[$];

  mem_lsu #(.ALLOW_UNALIGNED(1'b1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_op_i(req_op[0]),
    .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .resp_valid_o(resp_valid[0]), .resp_rdata_o(resp_rdata[0]), .resp_err_o(resp_err[0]),
    .dm_addr_o(dm_addr[0]), .dm_din_o(dm_din[0]), .dm_we_o(dm_we[0]),
    .dm_memRead_o(dm_memRead[0]), .dm_dout_i(dm_dout[0])
  );

  mem_lsu #(.ALLOW_UNALIGNED(1'b0)) dut_s (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_op_i(req_op[1]),
    .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .resp_valid_o(resp_valid[1]), .resp_rdata_o(resp_rdata[1]), .resp_err_o(resp_err[1]),
    .dm_addr_o(dm_addr[1]), .dm_din_o(dm_din[1]), .dm_we_o(dm_we[1]),
    .dm_memRead_o(dm_memRead[1]), .dm_dout_i(dm_dout[1])
  );

  // dm_4k stand-in: combinational read, write on falling edge.
  for (genvar s = 0; s < 2; s++) begin : g_mem
    logic [11:0] wa;
    logic [31:0] word;
    logic [7:0]  byt;
    assign wa   = {dm_addr[s][11:2], 2'b00};
    assign word = {dm_mem[s][wa + 12'd3], dm_mem[s][wa + 12'd2], dm_mem[s][wa + 12'd1], dm_mem[s][wa]};
    assign byt  = dm_mem[s][dm_addr[s]];
    assign dm_dout[s] = (dm_memRead[s] == 2'b01) ? word :
                        (dm_memRead[s] == 2'b10) ? {{24{byt[7]}}, byt} :
                        (dm_memRead[s] == 2'b11) ? {24'd0, byt} : 32'd0;
  end

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (dm_we[s] == 2'b01) begin
        for (int i = 0; i < 4; i++) dm_mem[s][{dm_addr[s][11:2], 2'b00} + 12'(i)] = dm_din[s][8*i +: 8];
      end else if (dm_we[s] == 2'b10) begin
        dm_mem[s][dm_addr[s]] = dm_din[s][7:0];
      end
    end
  end

  // Reference: byte-addressed memory, little-endian, addresses wrap at 4096.
  task automatic ref_access(input int s, input logic [2:0] op, input logic [11:0] a,
                            input logic [31:0] wd, output logic [31:0] rd,
                            output logic err, output int n);
    int nb;
    logic [31:0] v;
    nb  = (op == LW || op == SW) ? 4 : (op == LH || op == LHU || op == SH) ? 2 : 1;
    err = (s == 1) && (nb > 1) && ((int'(a) % nb) != 0);
    rd  = 32'd0;
    n   = 0;
    if (!err) begin
      n = (nb == 1) ? 1 : (nb == 2) ? 2 : ((int'(a) % 4 == 0) ? 1 : 4);
      if (op >= SW) begin
        for (int i = 0; i < nb; i++) ref_mem[s][(int'(a) + i) % 4096] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[s][(int'(a) + i) % 4096]) << (8*i));
        if (op == LH && v[15]) v = v | 32'hFFFF0000;
        if (op == LB && v[7])  v = v | 32'hFFFFFF00;
        rd = v;
      end
    end
  endtask

  // Issues one request from IDLE; lat = edges after accept until resp_valid, busy = samples with ready low.
  task automatic do_req(input int s, input logic [2:0] op, input logic [11:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic err, output int busy);
    we_log.delete(); rd_log.delete(); addr_log.delete(); din_log.delete();
    req_op[s] = op; req_addr[s] = a; req_wdata[s] = wd; req_valid[s] = 1'b1;
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    lat = 0; busy = 0;
    while (1) begin
      if (!req_ready[s]) busy++;
      if (dm_we[s] != 2'b00 || dm_memRead[s] != 2'b00) begin
        we_log.push_back(dm_we[s]); rd_log.push_back(dm_memRead[s]);
        addr_log.push_back(dm_addr[s]); din_log.push_back(dm_din[s][7:0]);
      end
      if (resp_valid[s] || lat >= 12) break;
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata[s]; err = resp_err[s];
    if (!resp_valid[s]) lat = -1;
    @(posedge clk); #1;
    if (!req_ready[s]) busy++;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++; if (req_ready[s] !== 1'b1) begin failures++; $display("FAIL reset_ready[%0d]: got %b want 1", s, req_ready[s]); end
      checks++; if (resp_valid[s] !== 1'b0 || resp_err[s] !== 1'b0) begin failures++; $display("FAIL reset_resp_flags[%0d]: got v=%b e=%b want 0 0", s, resp_valid[s], resp_err[s]); end
      checks++; if (resp_rdata[s] !== 32'd0) begin failures++; $display("FAIL reset_rdata[%0d]: got %h want 0", s, resp_rdata[s]); end
      checks++; if (dm_we[s] !== 2'b00 || dm_memRead[s] !== 2'b00 || dm_addr[s] !== 12'd0 || dm_din[s] !== 32'd0) begin
        failures++; $display("FAIL reset_dm[%0d]: got we=%b rd=%b addr=%h din=%h want all 0", s, dm_we[s], dm_memRead[s], dm_addr[s], dm_din[s]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready[0] !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got %b want 1", req_ready[0]); end
  endtask

  task automatic test_aligned_word();
    int lat, busy, en; logic [31:0] rd, erd; logic err, eerr;
    ref_access(0, SW, 12'h010, 32'h12345678, erd, eerr, en);
    do_req(0, SW, 12'h010, 32'h12345678, lat, rd, err, busy);
    checks++; if (lat != 1) begin failures++; $display("FAIL sw_aligned_latency: got %0d want 1", lat); end
    checks++; if (we_log.size() != 1 || we_log[0] !== 2'b01 || addr_log[0] !== 12'h010) begin
      failures++; $display("FAIL sw_aligned_we: got %0d active cycles want 1 cycle of SW at 010", we_log.size());
    end
    ref_access(0, LW, 12'h010, 32'd0, erd, eerr, en);
    do_req(0, LW, 12'h010, 32'd0, lat, rd, err, busy);
    checks++; if (rd !== 32'h12345678 || lat != 1) begin failures++; $display("FAIL lw_aligned: got %h lat %0d want 12345678 lat 1", rd, lat); end
    checks++; if (rd_log.size() != 1 || rd_log[0] !== 2'b01) begin failures++; $display("FAIL lw_aligned_memread: got %0d reads want one LW", rd_log.size()); end
  endtask

  task automatic test_unaligned_word();
    int lat, busy, en; logic [31:0] rd, erd; logic err, eerr;
    logic [31:0] wd;
    logic [11:0] la[3];
    logic [31:0] lv[3];
    wd = 32'hAABBCCDD;
    la[0] = 12'h013; la[1] = 12'h010; la[2] = 12'h014;
    lv[0] = 32'hAABBCCDD; lv[1] = 32'hDD345678; lv[2] = 32'h00AABBCC;
    ref_access(0, SW, 12'h013, wd, erd, eerr, en);
    do_req(0, SW, 12'h013, wd, lat, rd, err, busy);
    checks++; if (lat != 4) begin failures++; $display("FAIL sw_split_latency: got %0d want 4", lat); end
    checks++; if (we_log.size() != 4) begin failures++; $display("FAIL sw_split_steps: got %0d want 4", we_log.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (we_log[i] !== 2'b10 || addr_log[i] !== 12'(12'h013 + i) || din_log[i] !== wd[8*i +: 8]) begin
          failures++; $display("FAIL sw_split_step%0d: got we=%b addr=%h din=%h want 10 %h %h", i, we_log[i], addr_log[i], din_log[i], 12'(12'h013 + i), wd[8*i +: 8]);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      ref_access(0, LW, la[i], 32'd0, erd, eerr, en);
      do_req(0, LW, la[i], 32'd0, lat, rd, err, busy);
      checks++; if (rd !== lv[i] || rd !== erd || lat != en) begin
        failures++; $display("FAIL lw_after_split@%h: got %h lat %0d want %h lat %0d", la[i], rd, lat, lv[i], en);
      end
    end
  endtask

  task automatic test_halfword();
    int lat, busy, en; logic [31:0] rd, erd; logic err, eerr;
    ref_access(0, SH, 12'h021, 32'h00008001, erd, eerr, en);
    do_req(0, SH, 12'h021, 32'h00008001, lat, rd, err, busy);
    checks++; if (lat != 2 || we_log.size() != 2) begin failures++; $display("FAIL sh_split: got lat %0d steps %0d want 2 2", lat, we_log.size()); end
    do_req(0, LH, 12'h021, 32'd0, lat, rd, err, busy);
    checks++; if (rd !== 32'hFFFF8001 || lat != 2) begin failures++; $display("FAIL lh_sign: got %h lat %0d want ffff8001 lat 2", rd, lat); end
    do_req(0, LHU, 12'h021, 32'd0, lat, rd, err, busy);
    checks++; if (rd !== 32'h00008001 || lat != 2) begin failures++; $display("FAIL lhu_zero: got %h lat %0d want 00008001 lat 2", rd, lat); end
    do_req(0, LB, 12'h022, 32'd0, lat, rd, err, busy);
    checks++; if (rd !== 32'hFFFFFF80 || lat != 1) begin failures++; $display("FAIL lb_sign: got %h lat %0d want ffffff80 lat 1", rd, lat); end
  endtask

  task automatic test_wrap();
    int lat, busy, en; logic [31:0] rd, erd; logic err, eerr;
    logic [11:0] ea[4];
    ea[0] = 12'hFFE; ea[1] = 12'hFFF; ea[2] = 12'h000; ea[3] = 12'h001;
    ref_access(0, SW, 12'hFFE, 32'h01020304, erd, eerr, en);
    do_req(0, SW, 12'hFFE, 32'h01020304, lat, rd, err, busy);
    checks++; if (busy != 5) begin failures++; $display("FAIL wrap_ready_low: got %0d cycles want 5", busy); end
    checks++; if (addr_log.size() != 4 || addr_log[0] !== ea[0] || addr_log[1] !== ea[1] || addr_log[2] !== ea[2] || addr_log[3] !== ea[3]) begin
      failures++; $display("FAIL wrap_addresses: got %0d steps want SB at ffe fff 000 001", addr_log.size());
    end
    do_req(0, LW, 12'h000, 32'd0, lat, rd, err, busy);
    checks++; if (rd !== 32'h00000102) begin failures++; $display("FAIL wrap_lw: got %h want 00000102", rd); end
  endtask

  task automatic test_reject();
    int lat, busy, en; logic [31:0] rd, erd; logic err, eerr;
    logic [2:0]  ops[5];
    logic [11:0] adr[5];
    ops[0] = SW; adr[0] = 12'h006;
    ops[1] = LW; adr[1] = 12'h004;
    ops[2] = LH; adr[2] = 12'h003;
    ops[3] = SH; adr[3] = 12'h002;
    ops[4] = LHU; adr[4] = 12'h002;
    for (int i = 0; i < 5; i++) begin
      ref_access(1, ops[i], adr[i], 32'h0000BEEF, erd, eerr, en);
      do_req(1, ops[i], adr[i], 32'h0000BEEF, lat, rd, err, busy);
      checks++; if (err !== eerr || rd !== erd || lat != en) begin
        failures++; $display("FAIL reject_case%0d: got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=%0d", i, err, rd, lat, eerr, erd, en);
      end
      checks++; if (we_log.size() + rd_log.size() != 2 * en) begin
        failures++; $display("FAIL reject_dm_activity%0d: got %0d active cycles want %0d", i, we_log.size(), en);
      end
    end
    checks++; if (rd !== 32'h0000BEEF) begin failures++; $display("FAIL reject_lhu_readback: got %h want 0000beef", rd); end
  endtask

  task automatic test_random();
    int lat, busy, en; logic [31:0] rd, erd, wd; logic err, eerr;
    logic [2:0] op; logic [11:0] a;
    for (int t = 0; t < 60; t++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 12'(32'hFFC + $urandom_range(0, 7)) : 12'(32'h0F8 + $urandom_range(0, 15));
      wd = $urandom;
      ref_access(0, op, a, wd, erd, eerr, en);
      do_req(0, op, a, wd, lat, rd, err, busy);
      checks++; if (rd !== erd || err !== eerr || lat != en) begin
        failures++; $display("FAIL random%0d op=%0d addr=%h: got %h err %b lat %0d want %h err %b lat %0d", t, op, a, rd, err, lat, erd, eerr, en);
      end
      checks++; if (we_log.size() != en) begin
        failures++; $display("FAIL random%0d_steps: got %0d want %0d", t, we_log.size(), en);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] erd_a, erd_b; logic eerr; int en_a, en_b;
    int acc, b_edge, nresp;
    logic [31:0] rlist[$];
    bit acc_now;
    ref_access(0, SW, 12'h031, 32'h11223344, erd_a, eerr, en_a);
    ref_access(0, LW, 12'h031, 32'd0, erd_b, eerr, en_b);
    acc = 0; b_edge = -1; nresp = 0;
    req_op[0] = SW; req_addr[0] = 12'h031; req_wdata[0] = 32'h11223344; req_valid[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      acc_now = req_ready[0] && req_valid[0];
      @(posedge clk); #1;
      if (acc_now) begin
        acc++;
        if (acc == 1) begin req_op[0] = LW; req_wdata[0] = 32'd0; end
        if (acc == 2) begin req_valid[0] = 1'b0; b_edge = c; end
      end
      if (resp_valid[0]) begin nresp++; rlist.push_back(resp_rdata[0]); end
    end
    req_valid[0] = 1'b0;
    checks++; if (acc != 2 || nresp != 2) begin failures++; $display("FAIL b2b_counts: got %0d accepts %0d resps want 2 2", acc, nresp); end
    checks++; if (b_edge != en_a + 2) begin failures++; $display("FAIL b2b_second_accept: got edge %0d want %0d", b_edge, en_a + 2); end
    checks++; if (rlist.size() < 2 || rlist[1] !== erd_b || erd_b !== 32'h11223344) begin
      failures++; $display("FAIL b2b_readback: got %h want %h", (rlist.size() > 1) ? rlist[1] : 32'hX, erd_b);
    end
  endtask

  task automatic test_reset_midop();
    int nresp;
    logic [7:0] old42;
    old42 = ref_mem[0][12'h042];
    req_op[0] = SW; req_addr[0] = 12'h041; req_wdata[0] = 32'hAABBCCDD; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    checks++; if (dm_we[0] !== 2'b10 || dm_addr[0] !== 12'h042) begin failures++; $display("FAIL midop_second_sb: got we=%b addr=%h want 10 042", dm_we[0], dm_addr[0]); end
    rst_n = 1'b0;
    #1;
    checks++; if (dm_we[0] !== 2'b00 || req_ready[0] !== 1'b1) begin failures++; $display("FAIL midop_reset_async: got we=%b ready=%b want 00 1", dm_we[0], req_ready[0]); end
    ref_mem[0][12'h041] = 8'hDD;
    nresp = 0;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (resp_valid[0]) nresp++;
    end
    checks++; if (nresp != 0) begin failures++; $display("FAIL midop_no_resp: got %0d pulses want 0", nresp); end
    checks++; if (dm_mem[0][12'h041] !== 8'hDD || dm_mem[0][12'h042] !== old42) begin
      failures++; $display("FAIL midop_memory: got 041=%h 042=%h want dd %h", dm_mem[0][12'h041], dm_mem[0][12'h042], old42);
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_op[s] = 3'd0; req_addr[s] = 12'd0; req_wdata[s] = 32'd0;
    end
    test_reset();
    test_aligned_word();
    test_unaligned_word();
    test_halfword();
    test_wrap();
    test_reject();
    test_random();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
